// File: rtl/mixer_seq_ctrl.sv
// Mixer step sequencer.
// For each step 0..LAST_STEP it counts the rising edges of the pulse pin over a
// fixed gate window. It then offers the count to the UART reporter over a
// valid/ready port, and strobes uart_pulse once for each accepted report.
module mixer_seq_ctrl #(
    parameter int GATE_CYCLES = 4000,
    parameter int CNT_W       = 16,
    parameter int LAST_STEP   = 3,
    parameter int PULSE_W     = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [4:0]       outs,
    output logic             busy,
    output logic             done,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_data,
    output logic [4:0]       rpt_step,
    output logic             uart_pulse
);

    localparam int GW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int PW_W = $clog2(PULSE_W + 1);

    localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [4:0]       STEP_LAST  = 5'(LAST_STEP);
    localparam logic [PW_W-1:0]  PULSE_LOAD = PW_W'(PULSE_W);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_REPORT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        outs_q, outs_d;
    logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0]  rpt_data_q, rpt_data_d;
    logic [4:0]        rpt_step_q, rpt_step_d;
    logic [PW_W-1:0]   pulse_cnt_q, pulse_cnt_d;

    logic              s1_q, s2_q, s3_q;
    logic              pin_rise;
    logic [CNT_W-1:0]  edge_sum;

    // Two-flop synchroniser for the asynchronous pin, plus one flop for edge detection.
    // NOTE: registers are written with non-blocking assignments, so every flop
    // samples the value from before the edge and the shift chain stays a real chain.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pulse_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pin_rise = s2_q & ~s3_q;

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            outs_q      <= '0;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            rpt_valid_q <= 1'b0;
            rpt_data_q  <= '0;
            rpt_step_q  <= '0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            outs_q      <= outs_d;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_data_q  <= rpt_data_d;
            rpt_step_q  <= rpt_step_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // Next-state logic: gate windowing, report handshake, step advance, and abort.
    // NOTE: every signal gets a default at the top of the block, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        outs_d      = outs_q;
        gate_cnt_d  = gate_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        rpt_valid_d = rpt_valid_q;
        rpt_data_d  = rpt_data_q;
        rpt_step_d  = rpt_step_q;
        pulse_cnt_d = (pulse_cnt_q != '0) ? pulse_cnt_q - PW_W'(1) : '0;
        edge_sum    = (pin_rise && edge_cnt_q != CNT_MAX) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

        if (state_q != S_IDLE && !enable) begin
            // Abort: drop any pending report without a handshake.
            state_d     = S_IDLE;
            outs_d      = '0;
            rpt_valid_d = 1'b0;
            pulse_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d    = S_GATE;
                        outs_d     = '0;
                        gate_cnt_d = '0;
                        edge_cnt_d = '0;
                    end
                end
                S_GATE: begin
                    // The edge seen in the last gate cycle still belongs to this window.
                    edge_cnt_d = edge_sum;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d     = S_REPORT;
                        rpt_data_d  = edge_sum;
                        rpt_step_d  = outs_q;
                        rpt_valid_d = 1'b1;
                    end else begin
                        gate_cnt_d = gate_cnt_q + GW'(1);
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_d = 1'b0;
                        pulse_cnt_d = PULSE_LOAD;
                        if (outs_q == STEP_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_GATE;
                            outs_d     = outs_q + 5'd1;
                            gate_cnt_d = '0;
                            edge_cnt_d = '0;
                        end
                    end
                end
                S_DONE: begin
                    // Hold until enable drops, which the abort path above handles.
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign outs       = outs_q;
    assign busy       = (state_q == S_GATE) || (state_q == S_REPORT);
    assign done       = (state_q == S_DONE);
    assign rpt_valid  = rpt_valid_q;
    assign rpt_data   = rpt_data_q;
    assign rpt_step   = rpt_step_q;
    assign uart_pulse = (pulse_cnt_q != '0);

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// Testbench for mixer_seq_ctrl.
// Two instances share all of their inputs: a 16-bit counter and a 4-bit
// saturating counter. A step-level model predicts the outputs of both.
module tb_mixer_seq_ctrl;

    localparam int GC     = 1000;
    localparam int PW     = 8;
    localparam int LAST   = 3;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 15;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic enable = 1'b0;
    logic rpt_ready = 1'b0;
    logic gen_pin = 1'b0;
    logic man_pin = 1'b0;
    logic pulse_en = 1'b0;
    wire  pulse_in = gen_pin | man_pin;

    logic [4:0]  outs_a, outs_b, step_a, step_b;
    logic        busy_a, busy_b, done_a, done_b, valid_a, valid_b, up_a, up_b;
    logic [15:0] data_a;
    logic [3:0]  data_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mixer_seq_ctrl #(.GATE_CYCLES(GC), .CNT_W(16), .LAST_STEP(LAST), .PULSE_W(PW)) u_dut (
        .clock(clk), .resetb(resetb), .enable(enable), .pulse_in(pulse_in),
        .outs(outs_a), .busy(busy_a), .done(done_a), .rpt_valid(valid_a),
        .rpt_ready(rpt_ready), .rpt_data(data_a), .rpt_step(step_a), .uart_pulse(up_a)
    );

    mixer_seq_ctrl #(.GATE_CYCLES(GC), .CNT_W(4), .LAST_STEP(LAST), .PULSE_W(PW)) u_sat (
        .clock(clk), .resetb(resetb), .enable(enable), .pulse_in(pulse_in),
        .outs(outs_b), .busy(busy_b), .done(done_b), .rpt_valid(valid_b),
        .rpt_ready(rpt_ready), .rpt_data(data_b), .rpt_step(step_b), .uart_pulse(up_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 1 MHz stimulus relative to a 40 MHz clock: 40 clocks per period, 20 high.
    int ph = 0;
    always @(negedge clk) begin
        if (pulse_en) begin
            ph = (ph + 1) % 40;
            gen_pin = (ph >= 20);
        end else begin
            ph = 0;
            gen_pin = 1'b0;
        end
    end

    // Behavioural model. A pin rise first seen at clock edge n is counted at
    // edge n+2, but only while a gate window is open.
    int m_cyc, m_phase, m_step, m_gate, m_cnt, m_data, m_rstep, m_pulse;
    bit m_valid, m_prev_pin, m_edge;
    int m_due[$];

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_phase = 0; m_step = 0; m_gate = 0; m_cnt = 0; m_data = 0; m_rstep = 0;
            m_pulse = 0; m_valid = 0; m_prev_pin = 0; m_due.delete();
        end else begin
            m_cyc++;
            m_edge = (m_due.size() > 0 && m_due[0] == m_cyc);
            if (m_edge) void'(m_due.pop_front());
            if (pulse_in && !m_prev_pin) m_due.push_back(m_cyc + 2);
            m_prev_pin = pulse_in;
            if (m_pulse > 0) m_pulse--;
            if (m_phase != 0 && !enable) begin
                m_phase = 0; m_step = 0; m_valid = 0; m_pulse = 0;
            end else begin
                case (m_phase)
                    0: if (enable) begin m_phase = 1; m_step = 0; m_gate = 0; m_cnt = 0; end
                    1: begin
                        m_cnt += int'(m_edge);
                        if (m_gate == GC - 1) begin
                            m_phase = 2; m_data = m_cnt; m_rstep = m_step; m_valid = 1;
                        end else m_gate++;
                    end
                    2: if (rpt_ready) begin
                        m_valid = 0; m_pulse = PW;
                        if (m_step == LAST) m_phase = 3;
                        else begin m_phase = 1; m_step++; m_gate = 0; m_cnt = 0; end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare both instances with the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        check("outs_a", outs_a, m_step);
        check("outs_b", outs_b, m_step);
        check("busy_a", busy_a, (m_phase == 1 || m_phase == 2));
        check("busy_b", busy_b, (m_phase == 1 || m_phase == 2));
        check("done_a", done_a, (m_phase == 3));
        check("done_b", done_b, (m_phase == 3));
        check("valid_a", valid_a, m_valid);
        check("valid_b", valid_b, m_valid);
        check("uart_a", up_a, (m_pulse > 0));
        check("uart_b", up_b, (m_pulse > 0));
        if (m_valid) begin
            check("data_a", data_a, (m_data > MAX_A) ? MAX_A : m_data);
            check("data_b", data_b, (m_data > MAX_B) ? MAX_B : m_data);
            check("step_a", step_a, m_rstep);
            check("step_b", step_b, m_rstep);
        end
    end

    // Record accepted reports and the length of each uart_pulse strobe.
    int rep_data[$], rep_step[$], rep_sat[$], widths[$];
    int run = 0;
    always @(posedge clk) begin
        if (resetb && valid_a && rpt_ready) begin
            rep_data.push_back(int'(data_a));
            rep_step.push_back(int'(step_a));
            rep_sat.push_back(int'(data_b));
        end
        if (up_a) run++;
        else if (run > 0) begin
            widths.push_back(run);
            run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for a DUT condition with a cycle budget. sel: 0 done, 1 outs==arg, 2 valid, 3 busy.
    task automatic wait_cond(input int sel, input int arg, input int budget, input string name);
        int n = 0;
        bit hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0: hit = done_a;
                1: hit = (int'(outs_a) == arg);
                2: hit = valid_a;
                default: hit = busy_a;
            endcase
        end
        check(name, hit, 1);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, wbase, d0;

        // Reset values
        #1;
        check("rst_outs", outs_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_step", step_a, 0);
        check("rst_uart", up_a, 0);
        tick(3);
        resetb = 1'b1;
        tick(2);

        // Test 1: 1 MHz input with ready tied high; the 4-bit instance saturates at 15
        base = rep_data.size(); wbase = widths.size();
        pulse_en = 1; rpt_ready = 1; enable = 1;
        wait_cond(0, 0, 6000, "t1_done_reached");
        tick(12);
        check("t1_nrep", rep_data.size() - base, 4);
        for (int i = 0; i < 4 && base + i < rep_data.size(); i++) begin
            check("t1_data_25pm1", (rep_data[base+i] >= 24 && rep_data[base+i] <= 26), 1);
            check("t1_step", rep_step[base+i], i);
            check("t1_sat15", rep_sat[base+i], 15);
        end
        check("t1_nstrobe", widths.size() - wbase, 4);
        for (int i = wbase; i < widths.size(); i++) check("t1_strobe_w", widths[i], 8);
        check("t1_done", done_a, 1);
        check("t1_outs", outs_a, 3);
        enable = 0;
        tick(1);
        check("t1_idle_done", done_a, 0);
        check("t1_idle_outs", outs_a, 0);

        // Test 2: pin held low, so every count is zero
        pulse_en = 0;
        tick(45);
        base = rep_data.size();
        enable = 1;
        wait_cond(0, 0, 6000, "t2_done_reached");
        check("t2_nrep", rep_data.size() - base, 4);
        for (int i = base; i < rep_data.size(); i++) begin
            check("t2_data0", rep_data[i], 0);
            check("t2_sat0", rep_sat[i], 0);
        end
        enable = 0;
        tick(2);

        // Test 3: ready held low during the step-1 report
        base = rep_data.size();
        pulse_en = 1; rpt_ready = 1; enable = 1;
        wait_cond(1, 1, 1200, "t3_step1");
        rpt_ready = 0;
        wait_cond(2, 0, 1200, "t3_valid");
        d0 = int'(data_a);
        check("t3_step", step_a, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t3_hold_valid", valid_a, 1);
            check("t3_hold_data", data_a, d0);
            check("t3_hold_step", step_a, 1);
            check("t3_no_uart", up_a, 0);
        end
        rpt_ready = 1;
        @(negedge clk);
        check("t3_outs2", outs_a, 2);
        check("t3_busy", busy_a, 1);
        check("t3_valid_low", valid_a, 0);
        check("t3_uart_on", up_a, 1);
        wait_cond(0, 0, 4000, "t3_done_reached");
        check("t3_nrep", rep_data.size() - base, 4);
        enable = 0;
        tick(2);

        // Test 4: abort in the middle of step 2, then restart from step 0
        base = rep_data.size();
        enable = 1;
        wait_cond(1, 2, 2500, "t4_step2");
        tick(500);
        enable = 0;
        @(negedge clk);
        check("t4_outs0", outs_a, 0);
        check("t4_busy0", busy_a, 0);
        check("t4_valid0", valid_a, 0);
        check("t4_nrep", rep_data.size() - base, 2);
        tick(5);
        enable = 1;
        @(negedge clk);
        check("t4_restart_busy", busy_a, 1);
        check("t4_restart_outs", outs_a, 0);
        wait_cond(0, 0, 6000, "t4_done_reached");
        check("t4_nrep_total", rep_data.size() - base, 6);
        enable = 0;
        tick(2);

        // Test 6a: a rise on the last gate cycle is counted; a rise during REPORT is not
        pulse_en = 0;
        tick(45);
        base = rep_data.size();
        rpt_ready = 0;
        enable = 1;
        wait_cond(3, 0, 10, "t6_busy");
        repeat (GC - 3) @(negedge clk);
        man_pin = 1;
        @(negedge clk) man_pin = 0;
        @(negedge clk) man_pin = 1;
        @(negedge clk) man_pin = 0;
        tick(3);
        check("t6_valid", valid_a, 1);
        check("t6_edge_last_cycle", data_a, 1);
        check("t6_step0", step_a, 0);

        // Test 6b: asynchronous reset in the middle of REPORT
        @(posedge clk);
        #2 resetb = 0;
        #1;
        check("t6_rst_valid", valid_a, 0);
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_data", data_a, 0);
        check("t6_rst_step", step_a, 0);
        check("t6_rst_outs", outs_a, 0);
        check("t6_rst_uart", up_a, 0);
        enable = 0;
        tick(2);
        resetb = 1;
        tick(3);
        check("t6_no_report", rep_data.size() - base, 0);
        check("t6_idle", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
